// File: rtl/arb_pkg.sv
// Shared definitions for the 8-requester round-robin arbiter.
// Holds the requester count, the owner ID width, the FSM states and the grant/mask helpers.
package arb_pkg;

  localparam int NUM_REQ = 8;
  localparam int ID_W    = 3;

  typedef enum logic {
    IDLE,
    GRANT
  } state_t;

  function automatic logic [NUM_REQ-1:0] onehot(input logic [ID_W-1:0] k);
    return NUM_REQ'(1) << k;
  endfunction

  // Requesters strictly below k are next in line; k=0 yields an empty mask (full wrap).
  function automatic logic [NUM_REQ-1:0] mask_below(input logic [ID_W-1:0] k);
    return onehot(k) - NUM_REQ'(1);
  endfunction

endpackage

// File: rtl/priority_encoder.sv
// 8-input priority encoder: highest set index wins, valid flags any set input.
module priority_encoder (
  input  logic [7:0] a,
  output logic [2:0] y,
  output logic       valid
);

  always_comb begin
    y     = '0;
    valid = |a;
    for (int i = 0; i < 8; i++) begin
      if (a[i]) y = 3'(i);
    end
  end

endmodule

// File: rtl/rr_priority_arbiter.sv
// Round-robin arbiter for 8 requesters with a rotating mask and an optional hold limit
// that preempts a long-running owner when someone else is waiting.
module rr_priority_arbiter
  import arb_pkg::*;
#(
  parameter int MAX_HOLD = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NUM_REQ-1:0]  req,
  output logic [NUM_REQ-1:0]  gnt,
  output logic [ID_W-1:0]     gnt_id,
  output logic                gnt_valid
);

  localparam int CNT_W = (MAX_HOLD < 1) ? 1 : $clog2(MAX_HOLD + 1);
  localparam logic [CNT_W-1:0] HOLD_LIM = CNT_W'(MAX_HOLD);

  state_t             state;
  logic [NUM_REQ-1:0] mask;
  logic [CNT_W-1:0]   hold_cnt;

  logic [NUM_REQ-1:0] req_excl;
  logic [NUM_REQ-1:0] masked;
  logic [NUM_REQ-1:0] search;
  logic [ID_W-1:0]    winner;
  logic               winner_vld;
  logic               owner_req;
  logic               limit_hit;
  logic               take;
  logic               drop;

  // The current owner never competes against itself; gnt is zero when idle.
  assign req_excl  = req & ~gnt;
  assign masked    = req_excl & mask;
  assign search    = (masked != '0) ? masked : req_excl;
  assign owner_req = |(req & gnt);
  assign limit_hit = (MAX_HOLD != 0) && (hold_cnt == HOLD_LIM);

  priority_encoder u_penc (
    .a     (search),
    .y     (winner),
    .valid (winner_vld)
  );

  always_comb begin
    take = 1'b0;
    drop = 1'b0;
    case (state)
      IDLE:    take = winner_vld;
      GRANT: begin
        if (owner_req) begin
          take = limit_hit && winner_vld;
        end else begin
          take = winner_vld;
          drop = !winner_vld;
        end
      end
      default: take = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      gnt       <= '0;
      gnt_id    <= '0;
      gnt_valid <= 1'b0;
      mask      <= '1;
      hold_cnt  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (take) begin
            state     <= GRANT;
            gnt       <= onehot(winner);
            gnt_id    <= winner;
            gnt_valid <= 1'b1;
            mask      <= mask_below(winner);
            hold_cnt  <= '0;
          end
        end
        GRANT: begin
          if (take) begin
            gnt       <= onehot(winner);
            gnt_id    <= winner;
            mask      <= mask_below(winner);
            hold_cnt  <= '0;
          end else if (drop) begin
            state     <= IDLE;
            gnt       <= '0;
            gnt_id    <= '0;
            gnt_valid <= 1'b0;
          end else if (hold_cnt != HOLD_LIM) begin
            hold_cnt  <= hold_cnt + CNT_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rr_priority_arbiter.sv
// Scoreboard bench: two arbiters (hold limit 4 and unlimited) share stimulus and are
// compared every cycle against a behavioural model, plus directed checks.
`timescale 1ns/1ps
module tb_rr_priority_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] req;
  logic [7:0] gnt4, gnt0;
  logic [2:0] gnt_id4, gnt_id0;
  logic       gnt_valid4, gnt_valid0;

  int total = 0;
  int bad   = 0;

  int mv[2], mid[2], mmask[2], mcnt[2];
  logic [11:0] q4[$];
  logic [11:0] q0[$];

  always #5 clk = ~clk;

  rr_priority_arbiter #(.MAX_HOLD(4)) u_dut4 (
    .clk(clk), .rst(rst), .req(req),
    .gnt(gnt4), .gnt_id(gnt_id4), .gnt_valid(gnt_valid4)
  );

  rr_priority_arbiter #(.MAX_HOLD(0)) u_dut0 (
    .clk(clk), .rst(rst), .req(req),
    .gnt(gnt0), .gnt_id(gnt_id0), .gnt_valid(gnt_valid0)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int pick(input int v, input int m);
    int s;
    int w;
    s = ((v & m) != 0) ? (v & m) : v;
    w = -1;
    for (int i = 7; i >= 0; i--) begin
      if (w < 0 && ((s >> i) & 1) != 0) w = i;
    end
    return w;
  endfunction

  task automatic model_grant(input int k, input int w);
    mv[k]    = 1;
    mid[k]   = w;
    mmask[k] = (1 << w) - 1;
    mcnt[k]  = 0;
  endtask

  task automatic model_step(input int k, input logic [7:0] r, input logic rs);
    int lim;
    int own;
    lim = (k == 0) ? 4 : 0;
    own = 1 << mid[k];
    if (rs) begin
      mv[k] = 0; mid[k] = 0; mmask[k] = 255; mcnt[k] = 0;
    end else if (mv[k] == 0) begin
      if (r != 0) model_grant(k, pick(int'(r), mmask[k]));
    end else if ((int'(r) & own) != 0) begin
      if (lim == 0) begin
      end else if (mcnt[k] < lim) begin
        mcnt[k]++;
      end else if ((int'(r) & ~own & 255) != 0) begin
        model_grant(k, pick(int'(r) & ~own & 255, mmask[k]));
      end
    end else if (r != 0) begin
      model_grant(k, pick(int'(r), mmask[k]));
    end else begin
      mv[k] = 0; mid[k] = 0;
    end
  endtask

  function automatic logic [11:0] model_out(input int k);
    logic [7:0] g;
    g = (mv[k] != 0) ? 8'(1 << mid[k]) : 8'h00;
    return {(mv[k] != 0), 3'(mid[k]), g};
  endfunction

  task automatic step(input logic [7:0] r, input logic rs);
    logic [11:0] e;
    req = r;
    rst = rs;
    model_step(0, r, rs);
    model_step(1, r, rs);
    q4.push_back(model_out(0));
    q0.push_back(model_out(1));
    @(posedge clk);
    #1;
    e = q4.pop_front();
    check_val("sb_hold4", {20'h0, gnt_valid4, gnt_id4, gnt4}, {20'h0, e});
    e = q0.pop_front();
    check_val("sb_hold0", {20'h0, gnt_valid0, gnt_id0, gnt0}, {20'h0, e});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] r;
    logic       rs;
    req = 8'h00;
    rst = 1'b1;
    for (int k = 0; k < 2; k++) begin
      mv[k] = 0; mid[k] = 0; mmask[k] = 255; mcnt[k] = 0;
    end

    step(8'h00, 1'b1);
    step(8'h00, 1'b1);
    for (int i = 0; i < 10; i++) begin
      step(8'h00, 1'b0);
      check_val("idle_gnt", {24'h0, gnt0}, 32'h0);
      check_val("idle_valid", {31'h0, gnt_valid4}, 32'h0);
    end

    step(8'h06, 1'b0);
    check_val("first_gnt", {24'h0, gnt4}, 32'h04);
    check_val("first_id", {29'h0, gnt_id4}, 32'd2);
    step(8'h06, 1'b0);
    step(8'h06, 1'b0);
    check_val("held_gnt", {24'h0, gnt0}, 32'h04);
    step(8'h02, 1'b0);
    check_val("handoff_gnt", {24'h0, gnt4}, 32'h02);
    check_val("handoff_id", {29'h0, gnt_id0}, 32'd1);
    check_val("handoff_valid", {31'h0, gnt_valid4}, 32'd1);
    step(8'h00, 1'b0);

    step(8'h00, 1'b1);
    for (int i = 0; i < 30; i++) begin
      step(8'h81, 1'b0);
      check_val("preempt_id", {29'h0, gnt_id4}, ((i / 5) % 2 == 0) ? 32'd7 : 32'd0);
      check_val("nolimit_id", {29'h0, gnt_id0}, 32'd7);
    end

    step(8'h08, 1'b0);
    step(8'h08, 1'b0);
    check_val("own3_id", {29'h0, gnt_id4}, 32'd3);
    step(8'h00, 1'b0);
    check_val("release_valid", {31'h0, gnt_valid4}, 32'd0);
    check_val("release_gnt", {24'h0, gnt0}, 32'h0);
    step(8'h28, 1'b0);
    check_val("wrap_id4", {29'h0, gnt_id4}, 32'd5);
    check_val("wrap_id0", {29'h0, gnt_id0}, 32'd5);

    for (int i = 0; i < 50; i++) begin
      step(8'hFF, 1'b0);
      check_val("hold_forever", {29'h0, gnt_id0}, 32'd5);
    end
    step(8'hFF, 1'b1);
    check_val("rst_gnt", {24'h0, gnt0}, 32'h0);
    check_val("rst_id", {29'h0, gnt_id0}, 32'h0);
    check_val("rst_valid", {31'h0, gnt_valid0}, 32'h0);
    step(8'hFF, 1'b0);
    check_val("post_rst_id", {29'h0, gnt_id0}, 32'd7);
    check_val("post_rst_id4", {29'h0, gnt_id4}, 32'd7);

    r = 8'h00;
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 2) != 0) r = 8'($urandom);
      if ($urandom_range(0, 7) == 0) r = 8'h00;
      rs = ($urandom_range(0, 63) == 0);
      step(r, rs);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
